// File: rtl/lsu_multicycle.sv
// Multi-cycle load/store unit: accepts one sized access, drives an aligned variable-latency
// memory port, builds store byte lanes and sign/zero-extends load data.
module lsu_multicycle #(
    parameter int XLEN          = 64,
    parameter int AW            = 64,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [AW-1:0]     req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t state;

    logic [OB-1:0] off_l;
    logic [1:0]    size_l;
    logic          uns_l;
    logic          we_l;

    logic [OB-1:0]   req_off;
    logic [OB-1:0]   req_amask;
    logic [OB-1:0]   eff_off;
    logic            req_illegal;
    logic            req_mis;
    logic            req_fault;
    logic [XLEN-1:0] rd_shift;

    // Offset bits that must be zero for a naturally aligned access of this size.
    function automatic logic [OB-1:0] align_mask(input logic [1:0] size);
        return OB'((1 << size) - 1);
    endfunction

    function automatic logic [NB-1:0] lane_mask(input logic [1:0] size);
        int bytes;
        bytes = 1 << size;
        return (bytes >= NB) ? '1 : ((NB'(1) << bytes) - NB'(1));
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] d,
                                                    input logic [1:0]      size,
                                                    input logic            uns);
        int              nbits;
        logic [XLEN-1:0] keep;
        logic [XLEN-1:0] top;
        logic            fill;
        nbits = 8 << size;
        if (nbits > XLEN) nbits = XLEN;
        keep = (nbits >= XLEN) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
        top  = d >> (nbits - 1);
        fill = ~uns & top[0];
        return (d & keep) | ({XLEN{fill}} & ~keep);
    endfunction

    always_comb begin
        req_off     = req_addr[OB-1:0];
        req_amask   = align_mask(req_size);
        req_illegal = (XLEN == 32) && (req_size == 2'd3);
        req_mis     = (|(req_off & req_amask)) || req_illegal;
        req_fault   = req_mis && (MISALIGN_TRAP || req_illegal);
        // Without trapping, a misaligned access is pulled down to its natural alignment.
        eff_off     = req_off & ~req_amask;
    end

    assign rd_shift = mem_rdata >> {off_l, 3'b000};

    // Request latch: data only, captured on accept.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            we_l   <= req_we;
            size_l <= req_size;
            uns_l  <= req_unsigned;
            off_l  <= eff_off;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_misalign <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (req_fault) begin
                            state         <= RESP;
                            resp_valid    <= 1'b1;
                            resp_misalign <= 1'b1;
                            resp_rdata    <= '0;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[AW-1:OB], {OB{1'b0}}};
                            mem_wmask <= req_we ? (lane_mask(req_size) << eff_off) : '0;
                            mem_wdata <= req_we ? (req_wdata << {eff_off, 3'b000}) : '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        state     <= WAIT;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wmask <= '0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state         <= RESP;
                        resp_valid    <= 1'b1;
                        resp_misalign <= 1'b0;
                        resp_rdata    <= we_l ? '0 : load_extend(rd_shift, size_l, uns_l);
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    resp_valid    <= 1'b0;
                    resp_misalign <= 1'b0;
                    resp_rdata    <= '0;
                    req_ready     <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_multicycle.sv
// Randomized bench for lsu_multicycle: a transaction-level model predicts every memory-port and
// response value; a 32-bit non-trapping instance covers illegal size and forced alignment.
module tb_lsu_multicycle;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_misalign;
    logic [63:0] resp_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
    logic [1:0]  b_req_size;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_resp_valid, b_resp_misalign;
    logic [31:0] b_resp_rdata;
    logic        b_mem_req, b_mem_we, b_mem_gnt, b_mem_rvalid;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_wmask;

    lsu_multicycle #(.XLEN(64), .AW(64), .MISALIGN_TRAP(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misalign(resp_misalign), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

    lsu_multicycle #(.XLEN(32), .AW(32), .MISALIGN_TRAP(1'b0)) dut32 (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_size(b_req_size), .req_unsigned(b_req_unsigned),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .resp_valid(b_resp_valid),
        .resp_rdata(b_resp_rdata), .resp_misalign(b_resp_misalign), .mem_req(b_mem_req),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_wmask(b_mem_wmask), .mem_gnt(b_mem_gnt), .mem_rvalid(b_mem_rvalid),
        .mem_rdata(b_mem_rdata));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected transaction, set by the driver before each request.
    logic        busy, chk_en;
    logic        exp_fault, exp_we;
    logic [63:0] exp_addr, exp_wdata, exp_rdata;
    logic [7:0]  exp_mask;
    logic [63:0] last_rdata, last_addr, last_wdata;
    logic [7:0]  last_mask;
    logic        last_mis;

    function automatic logic [63:0] lanes(input logic [7:0] m);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) if (m[i]) r |= 64'hFF << (8 * i);
        return r;
    endfunction

    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] memdata);
        int off, nb;
        logic [63:0] v, keep;
        off = int'(addr[2:0]);
        nb  = 1 << size;
        exp_fault = (off % nb) != 0;
        exp_we    = we;
        exp_addr  = addr & ~64'h7;
        exp_mask  = we ? 8'(((1 << nb) - 1) << off) : 8'h00;
        exp_wdata = wdata << (8 * off);
        v = memdata >> (8 * off);
        if (nb < 8) begin
            keep = (64'd1 << (8 * nb)) - 64'd1;
            v = v & keep;
            if (!uns && (((v >> (8 * nb - 1)) & 64'd1) != 0)) v = v | ~keep;
        end
        exp_rdata = (we || exp_fault) ? 64'd0 : v;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", req_ready, !busy);
            if (mem_req) begin
                check("mem_req_legal", {busy, exp_fault}, 2'b10);
                check("mem_addr", mem_addr, exp_addr);
                check("mem_we", mem_we, exp_we);
                check("mem_wmask", mem_wmask, exp_mask);
                if (exp_we)
                    check("mem_wdata", mem_wdata & lanes(exp_mask), exp_wdata & lanes(exp_mask));
                last_addr  = mem_addr;
                last_mask  = mem_wmask;
                last_wdata = mem_wdata;
            end else begin
                check("mem_we_idle", mem_we, 1'b0);
                check("mem_wmask_idle", mem_wmask, 8'h00);
            end
            if (resp_valid) begin
                check("resp_busy", busy, 1'b1);
                check("resp_rdata", resp_rdata, exp_rdata);
                check("resp_misalign", resp_misalign, exp_fault);
                last_rdata = resp_rdata;
                last_mis   = resp_misalign;
            end
        end
    end

    // Issue one access; acts as a memory with g cycles of grant delay and r extra cycles before
    // completion, and throws junk onto inputs the unit must ignore.
    task automatic access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] memdata, input int g, input int r,
                          output int lat);
        int reqcnt, waitcnt, explat;
        logic granted;
        model(we, size, uns, addr, wdata, memdata);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        busy = 1'b1;
        reqcnt = 0; waitcnt = 0; granted = 1'b0; lat = 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            req_valid = 1'b1; req_we = 1'($urandom); req_size = 2'($urandom);
            req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
            if (resp_valid) begin
                lat = cyc;
                break;
            end
            if (mem_req) begin
                mem_rvalid = 1'($urandom);
                if (reqcnt == g) begin mem_gnt = 1'b1; granted = 1'b1; end
                reqcnt++;
            end else if (granted) begin
                mem_gnt = 1'($urandom);
                if (waitcnt == r) begin mem_rvalid = 1'b1; mem_rdata = memdata; end
                waitcnt++;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        explat = exp_fault ? 1 : 3 + g + r;
        check("latency", 64'(lat), 64'(explat));
        @(posedge clk); #1;
        busy = 1'b0;
        check("resp_single_pulse", resp_valid, 1'b0);
    endtask

    task automatic acc32(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] memdata, output int lat,
                         output logic [31:0] rdata, output logic mis, output logic saw,
                         output logic [31:0] maddr, output logic [3:0] mmask,
                         output logic [31:0] mwdata);
        logic granted;
        lat = 0; rdata = 'x; mis = 1'bx; saw = 1'b0; maddr = 'x; mmask = 'x; mwdata = 'x;
        granted = 1'b0;
        b_req_valid = 1'b1; b_req_we = we; b_req_size = size; b_req_unsigned = uns;
        b_req_addr = addr; b_req_wdata = wdata;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            b_mem_gnt = 1'b0; b_mem_rvalid = 1'b0;
            if (b_resp_valid) begin
                lat = cyc; rdata = b_resp_rdata; mis = b_resp_misalign;
                break;
            end
            if (b_mem_req) begin
                saw = 1'b1; maddr = b_mem_addr; mmask = b_mem_wmask; mwdata = b_mem_wdata;
                b_mem_gnt = 1'b1; granted = 1'b1;
            end else if (granted) begin
                b_mem_rvalid = 1'b1; b_mem_rdata = memdata;
            end
            @(posedge clk); #1;
        end
        b_mem_gnt = 1'b0; b_mem_rvalid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        logic [31:0] rd, ma, mw;
        logic mis, saw;
        logic [3:0] mm;
        rst = 1'b1; chk_en = 1'b0; busy = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 2'd0; b_req_unsigned = 1'b0;
        b_req_addr = '0; b_req_wdata = '0; b_mem_gnt = 1'b0; b_mem_rvalid = 1'b0;
        b_mem_rdata = '0;
        last_rdata = '0; last_addr = '0; last_wdata = '0; last_mask = '0; last_mis = 1'b0;
        exp_fault = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
        exp_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_misalign", resp_misalign, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we_mask", {mem_we, mem_wmask}, 9'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst32_req_ready", b_req_ready, 1'b1);
        rst = 1'b0; chk_en = 1'b1;

        // LD, minimum latency
        access(1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'd0, 64'h1122_3344_5566_7788, 0, 0, lat);
        check("t1_lat", 64'(lat), 64'd3);
        check("t1_rdata", last_rdata, 64'h1122_3344_5566_7788);
        check("t1_addr", last_addr, 64'h8000_0008);
        // LB / LBU of 0x80
        access(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 1, 0, lat);
        check("t2_lb", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        access(1'b0, 2'd0, 1'b1, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 1, lat);
        check("t2_lbu", last_rdata, 64'h0000_0000_0000_0080);
        // SH lane placement
        access(1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 64'd0, 0, 0, lat);
        check("t3_addr", last_addr, 64'h8000_0000);
        check("t3_mask", last_mask, 8'hC0);
        check("t3_wdata", last_wdata >> 48, 64'hABCD);
        check("t3_rdata", last_rdata, 64'd0);
        // Misaligned LW traps without a memory cycle
        access(1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, lat);
        check("t4_lat", 64'(lat), 64'd1);
        check("t4_mis", last_mis, 1'b1);
        check("t4_rdata", last_rdata, 64'd0);
        // Slow grant and completion
        access(1'b0, 2'd2, 1'b1, 64'h8000_0014, 64'd0, 64'hDEAD_BEEF_0BAD_F00D, 5, 2, lat);
        check("t5_lat", 64'(lat), 64'd10);
        check("t5_rdata", last_rdata, 64'h0000_0000_DEAD_BEEF);

        for (int i = 0; i < 300; i++)
            access(1'($urandom), 2'($urandom), 1'($urandom),
                   64'h8000_0000 + 64'($urandom_range(0, 255)), {$urandom, $urandom},
                   {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3), lat);

        // Reset while waiting for completion; the late completion must be dropped
        chk_en = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_addr = 64'h8000_0020;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("t6_mem_req", mem_req, 1'b1);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        check("t6_wait_busy", {mem_req, req_ready}, 2'b00);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h5555_AAAA_5555_AAAA;
        check("t6_after_rst", {mem_req, req_ready, resp_valid}, 3'b010);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t6_no_resp", {mem_req, req_ready, resp_valid}, 3'b010);
            @(posedge clk); #1;
        end
        chk_en = 1'b1;
        access(1'b0, 2'd1, 1'b0, 64'h8000_0022, 64'd0, 64'h0000_0000_F123_0000, 0, 0, lat);
        check("t6_recover", last_rdata, 64'hFFFF_FFFF_FFFF_F123);

        // 32-bit, non-trapping instance
        acc32(1'b1, 2'd3, 1'b0, 32'h100, 32'h1234_5678, 32'd0, lat, rd, mis, saw, ma, mm, mw);
        check("x32_sd_lat", 64'(lat), 64'd1);
        check("x32_sd_mis", {mis, saw}, 2'b10);
        check("x32_sd_rdata", rd, 32'd0);
        acc32(1'b0, 2'd1, 1'b0, 32'h101, 32'd0, 32'h1234_8765, lat, rd, mis, saw, ma, mm, mw);
        check("x32_lh_lat", 64'(lat), 64'd3);
        check("x32_lh_rdata", rd, 32'hFFFF_8765);
        check("x32_lh_mis", mis, 1'b0);
        check("x32_lh_addr", ma, 32'h100);
        acc32(1'b0, 2'd1, 1'b1, 32'h106, 32'd0, 32'h8001_0000, lat, rd, mis, saw, ma, mm, mw);
        check("x32_lhu_rdata", rd, 32'h0000_8001);
        acc32(1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_005A, 32'd0, lat, rd, mis, saw, ma, mm, mw);
        check("x32_sb_mask", mm, 4'h8);
        check("x32_sb_wdata", mw >> 24, 32'h5A);
        acc32(1'b1, 2'd2, 1'b0, 32'h102, 32'hCAFE_F00D, 32'd0, lat, rd, mis, saw, ma, mm, mw);
        check("x32_sw_forced", {ma, mm}, {32'h100, 4'hF});
        check("x32_sw_wdata", mw, 32'hCAFE_F00D);
        check("x32_sw_resp", {mis, rd}, 33'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
